mul_fs_seq: RTL and testbench

Sequential 8-bit unsigned multiply-add; the inverse of the DivFS divider.
Takes a quotient Q, divisor SC and remainder R, and reconstructs the dividend SBC = Q*SC + R using a shift-add datapath, one multiplier bit per clock.
Used as the companion checker/reconstructor next to DivFS, and as a general multiply-add unit.
Runs a start/busy/done handshake and also reports whether the input triple is a valid DivFS result.

---
 rtl/div8_pkg.sv | 20 ++
 rtl/mul_fs_dp.sv | 65 ++++++
 rtl/mul_fs_seq.sv | 124 ++++++++++++
 tb/tb_mul_fs_seq.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div8_pkg.sv
// -----------------------------------------------------------------------------
// div8_pkg
//   Shared definitions for the DivFS divider family and its companion
//   multiply-add reconstructor mul_fs_seq.
//   - W_DEFAULT : default operand width (result width is 2*W)
//   - CNT_W     : iteration counter width for the default width
//   - state_e   : controller FSM encoding (IDLE / RUN / DONE)
// -----------------------------------------------------------------------------
package div8_pkg;

    localparam int W_DEFAULT = 8;
    localparam int CNT_W     = $clog2(W_DEFAULT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : div8_pkg

// File: rtl/mul_fs_dp.sv
// -----------------------------------------------------------------------------
// mul_fs_dp
//   Shift-add datapath for Q*SC + R. Holds the accumulator (ACC), the shifted
//   multiplicand (MC) and the multiplier (MP), which consumes one bit per step.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load       : load ACC={0,R}, MC={0,SC}, MP=Q
//   step       : one shift-add iteration
//   q, sc, r   : operands, used only on load
//   acc_next   : ACC after the current iteration's conditional add
// -----------------------------------------------------------------------------
module mul_fs_dp
    import div8_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [W-1:0]     q,
    input  logic [W-1:0]     sc,
    input  logic [W-1:0]     r,
    output logic [2*W-1:0]   acc_next
);

    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] mc_q,  mc_d;
    logic [W-1:0]   mp_q,  mp_d;

    // Cannot overflow 2W bits: the worst case (2^W-1)^2 + (2^W-2) still fits.
    assign acc_next = acc_q + (mp_q[0] ? mc_q : '0);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        acc_d = acc_q;
        mc_d  = mc_q;
        mp_d  = mp_q;
        if (load) begin
            acc_d = {{W{1'b0}}, r};
            mc_d  = {{W{1'b0}}, sc};
            mp_d  = q;
        end else if (step) begin
            acc_d = acc_next;
            mc_d  = mc_q << 1;
            mp_d  = mp_q >> 1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its input from before the edge, independent of statement order.
        if (rst) begin
            acc_q <= '0;
            mc_q  <= '0;
            mp_q  <= '0;
        end else begin
            acc_q <= acc_d;
            mc_q  <= mc_d;
            mp_q  <= mp_d;
        end
    end

endmodule : mul_fs_dp

// File: rtl/mul_fs_seq.sv
// -----------------------------------------------------------------------------
// mul_fs_seq
//   Sequential unsigned multiply-add SBC = Q*SC + R, one multiplier bit per
//   clock, fixed latency of W RUN cycles. Also flags whether (Q,SC,R) is a legal
//   DivFS result (REM_ERR) and whether SBC fits in W bits (OVF).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : request, sampled only in IDLE
//   Q, SC, R   : multiplier, multiplicand, addend (captured on the start edge)
//   busy       : high during RUN
//   done       : one-cycle pulse in DONE; SBC/REM_ERR/OVF are valid
//   SBC        : result, held until the next RUN->DONE transition
//   REM_ERR    : R >= SC (always set when SC == 0)
//   OVF        : upper W bits of SBC are non-zero
// -----------------------------------------------------------------------------
module mul_fs_seq
    import div8_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     Q,
    input  logic [W-1:0]     SC,
    input  logic [W-1:0]     R,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   SBC,
    output logic             REM_ERR,
    output logic             OVF
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rem_err_int_q, rem_err_int_d;
    logic [2*W-1:0]  sbc_q, sbc_d;
    logic            rem_err_q, rem_err_d;
    logic            ovf_q, ovf_d;

    logic            dp_load, dp_step;
    logic [2*W-1:0]  acc_next;

    mul_fs_dp #(.W(W)) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (dp_load),
        .step     (dp_step),
        .q        (Q),
        .sc       (SC),
        .r        (R),
        .acc_next (acc_next)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_err_int_d = rem_err_int_q;
        sbc_d         = sbc_q;
        rem_err_d     = rem_err_q;
        ovf_d         = ovf_q;
        dp_load       = 1'b0;
        dp_step       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dp_load       = 1'b1;
                    cnt_d         = '0;
                    rem_err_int_d = (R >= SC);
                    state_d       = ST_RUN;
                end
            end
            ST_RUN: begin
                dp_step = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                // The final iteration's sum goes straight into the result
                // registers, so outputs appear together with done.
                if (cnt_q == CNT_LAST) begin
                    sbc_d     = acc_next;
                    ovf_d     = |acc_next[2*W-1:W];
                    rem_err_d = rem_err_int_q;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: all control and result registers are reset (they are few and
        // their reset values are architecturally visible); rst overrides start.
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            rem_err_int_q <= 1'b0;
            sbc_q         <= '0;
            rem_err_q     <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_err_int_q <= rem_err_int_d;
            sbc_q         <= sbc_d;
            rem_err_q     <= rem_err_d;
            ovf_q         <= ovf_d;
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign SBC     = sbc_q;
    assign REM_ERR = rem_err_q;
    assign OVF     = ovf_q;

endmodule : mul_fs_seq

// File: tb/tb_mul_fs_seq.sv
// -----------------------------------------------------------------------------
// tb_mul_fs_seq
//   Self-checking bench for mul_fs_seq. Expected results are computed with plain
//   integer arithmetic when a start is driven, queued, and popped when done
//   pulses. Inputs change and outputs are sampled 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_mul_fs_seq;
    import div8_pkg::*;

    localparam int W = W_DEFAULT;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   q_in, sc_in, r_in;
    logic           busy, done;
    logic [2*W-1:0] sbc;
    logic           rem_err, ovf;

    typedef struct {
        logic [2*W-1:0] sbc;
        logic           rem_err;
        logic           ovf;
    } exp_t;

    exp_t           exp_q[$];
    int             checks = 0;
    int             errors = 0;
    logic [2*W-1:0] last_sbc;

    mul_fs_seq #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .Q       (q_in),
        .SC      (sc_in),
        .R       (r_in),
        .busy    (busy),
        .done    (done),
        .SBC     (sbc),
        .REM_ERR (rem_err),
        .OVF     (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [W-1:0] q, input logic [W-1:0] sc, input logic [W-1:0] r);
        exp_t e;
        int   p;
        p         = int'(q) * int'(sc) + int'(r);
        e.sbc     = p[2*W-1:0];
        e.rem_err = (int'(r) >= int'(sc));
        e.ovf     = (p > 255);
        exp_q.push_back(e);
    endtask

    // One complete operation: start edge, W RUN cycles, DONE, back to IDLE.
    task automatic run_op(input logic [W-1:0] q, input logic [W-1:0] sc,
                          input logic [W-1:0] r, input bit toggle, input string name);
        int   cyc;
        bit   busy_bad, hold_bad;
        exp_t e;
        q_in = q; sc_in = sc; r_in = r; start = 1'b1;
        push_exp(q, sc, r);
        tick();
        start    = 1'b0;
        cyc      = 0;
        busy_bad = 1'b0;
        hold_bad = 1'b0;
        while (done !== 1'b1 && cyc < 20) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (sbc !== last_sbc) hold_bad = 1'b1;
            if (toggle) begin
                q_in  = 8'($urandom);
                sc_in = 8'($urandom);
                r_in  = 8'($urandom);
            end
            tick();
            cyc++;
        end
        checks++;
        if (cyc != W) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, W);
        end
        checks++;
        if (busy_bad) begin
            errors++;
            $display("FAIL %s busy: busy dropped during RUN, expected 1 for %0d cycles", name, W);
        end
        checks++;
        if (hold_bad) begin
            errors++;
            $display("FAIL %s hold: SBC changed during RUN, expected %0d held", name, last_sbc);
        end
        e = exp_q.pop_front();
        checks++;
        if (sbc !== e.sbc) begin
            errors++;
            $display("FAIL %s SBC: got %0d, expected %0d", name, sbc, e.sbc);
        end
        checks++;
        if (rem_err !== e.rem_err) begin
            errors++;
            $display("FAIL %s REM_ERR: got %b, expected %b", name, rem_err, e.rem_err);
        end
        checks++;
        if (ovf !== e.ovf) begin
            errors++;
            $display("FAIL %s OVF: got %b, expected %b", name, ovf, e.ovf);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_in_done: got %b, expected 0", name, busy);
        end
        last_sbc = e.sbc;
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: got %b one cycle later, expected 0", name, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; q_in = '0; sc_in = '0; r_in = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, rem_err, ovf} !== 4'b0000 || sbc !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b SBC=%0d REM_ERR=%b OVF=%b, expected all 0",
                     busy, done, sbc, rem_err, ovf);
        end
        last_sbc = '0;
    endtask

    task automatic test_basic_ops();
        run_op(8'd81, 8'd3,   8'd0,  1'b0, "op81x3");
        run_op(8'd3,  8'd26,  8'd22, 1'b0, "op3x26");
        run_op(8'd28, 8'd9,   8'd3,  1'b0, "op28x9");
        run_op(8'd1,  8'd255, 8'd0,  1'b0, "op1x255");
        run_op(8'd0,  8'd91,  8'd50, 1'b0, "op0x91");
        run_op(8'd38, 8'd6,   8'd3,  1'b0, "op38x6");
    endtask

    task automatic test_boundaries();
        run_op(8'd255, 8'd255, 8'd254, 1'b0, "max_ovf");
        run_op(8'd1,   8'd5,   8'd7,   1'b0, "rem_err");
        run_op(8'd7,   8'd0,   8'd0,   1'b0, "sc_zero");
        run_op(8'd0,   8'd200, 8'd9,   1'b0, "q_zero");
    endtask

    // Starts during RUN and DONE must be dropped, not queued.
    task automatic test_start_ignored();
        int   cyc;
        int   extra_done;
        bit   busy_seen;
        exp_t e;
        q_in = 8'd10; sc_in = 8'd10; r_in = 8'd0; start = 1'b1;
        push_exp(8'd10, 8'd10, 8'd0);
        tick();
        start = 1'b0;
        cyc   = 0;
        while (done !== 1'b1 && cyc < 20) begin
            if (cyc == 2) begin
                start = 1'b1; q_in = 8'd2; sc_in = 8'd2;
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        e = exp_q.pop_front();
        checks++;
        if (cyc != W || sbc !== e.sbc) begin
            errors++;
            $display("FAIL ignore_start result: latency %0d SBC %0d, expected %0d / %0d", cyc, sbc, W, e.sbc);
        end
        start = 1'b1; q_in = 8'd2; sc_in = 8'd2;
        tick();
        start      = 1'b0;
        extra_done = 0;
        busy_seen  = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done === 1'b1) extra_done++;
            if (busy === 1'b1) busy_seen = 1'b1;
            tick();
        end
        checks++;
        if (extra_done != 0 || busy_seen) begin
            errors++;
            $display("FAIL ignore_start second_op: extra done=%0d busy_seen=%b, expected 0 / 0", extra_done, busy_seen);
        end
        checks++;
        if (sbc !== 16'd100) begin
            errors++;
            $display("FAIL ignore_start hold: SBC got %0d, expected 100", sbc);
        end
        last_sbc = 16'd100;
    endtask

    // start held high: one op every W+2 cycles.
    task automatic test_back_to_back();
        int  done_at[$];
        bit  bad_sbc;
        bit  bad_gap;
        int  guard;
        q_in = 8'd3; sc_in = 8'd4; r_in = 8'd5; start = 1'b1;
        bad_sbc = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (done === 1'b1) begin
                done_at.push_back(c);
                if (sbc !== 16'd17) bad_sbc = 1'b1;
            end
        end
        start = 1'b0;
        guard = 0;
        while ((busy === 1'b1 || done === 1'b1) && guard < 20) begin
            tick();
            guard++;
        end
        checks++;
        if (done_at.size() != 4) begin
            errors++;
            $display("FAIL back_to_back count: got %0d done pulses, expected 4", done_at.size());
        end
        bad_gap = 1'b0;
        if (done_at.size() > 0 && done_at[0] != W + 1) bad_gap = 1'b1;
        for (int i = 1; i < done_at.size(); i++)
            if (done_at[i] - done_at[i-1] != W + 2) bad_gap = 1'b1;
        checks++;
        if (bad_gap) begin
            errors++;
            $display("FAIL back_to_back spacing: first done at %0d, expected %0d, period %0d", 
                     (done_at.size() > 0) ? done_at[0] : -1, W + 1, W + 2);
        end
        checks++;
        if (bad_sbc) begin
            errors++;
            $display("FAIL back_to_back SBC: a result differed from expected 17");
        end
        last_sbc = 16'd17;
    endtask

    task automatic test_reset_mid_op();
        int extra_done;
        q_in = 8'd50; sc_in = 8'd50; r_in = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, rem_err, ovf} !== 4'b0000 || sbc !== '0) begin
            errors++;
            $display("FAIL reset_mid_op: busy=%b done=%b SBC=%0d REM_ERR=%b OVF=%b, expected all 0",
                     busy, done, sbc, rem_err, ovf);
        end
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1 || busy === 1'b1) extra_done++;
            tick();
        end
        checks++;
        if (extra_done != 0) begin
            errors++;
            $display("FAIL reset_mid_op aborted: got %0d busy/done cycles, expected 0", extra_done);
        end
        last_sbc = '0;
        run_op(8'd12, 8'd12, 8'd11, 1'b0, "after_reset");
    endtask

    task automatic test_operand_toggle();
        bit bad;
        run_op(8'd200, 8'd150, 8'd77, 1'b1, "toggle_run");
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            q_in = 8'($urandom); sc_in = 8'($urandom); r_in = 8'($urandom);
            tick();
            if (sbc !== last_sbc || busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL idle_hold: SBC %0d busy %b done %b, expected %0d / 0 / 0", sbc, busy, done, last_sbc);
        end
    endtask

    initial begin
        test_reset();
        test_basic_ops();
        test_boundaries();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_op();
        test_operand_toggle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mul_fs_seq
